// File: rtl/enc_pkg.sv
// Shared definitions for the sequential 8-to-3 encoder.
package enc_pkg;

  localparam int unsigned N    = 8;
  localparam int unsigned CW   = 3;
  localparam int unsigned CNTW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Number of set bits in a request vector (0..N).
  function automatic logic [CNTW-1:0] popcount(input logic [N-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = c + {{(CNTW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_enc8_3.sv
// Combinational priority encoder: index of the highest set bit, 0 when empty.
module prio_enc8_3
  import enc_pkg::*;
(
  input  logic [N-1:0]  d,
  output logic [CW-1:0] idx,
  output logic          any
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    idx = '0;
    any = |d;
    for (int unsigned i = 0; i < N; i++) begin
      if (d[i]) idx = CW'(i);
    end
  end

endmodule

// File: rtl/enc8_3_seq.sv
// Sequential 8-to-3 encoder: latches a request vector and emits the index of
// every set bit, highest first, one code per valid/ready handshake.
module enc8_3_seq
  import enc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    a,
  output logic            ld_rdy,
  output logic [CW-1:0]   y,
  output logic            vld,
  input  logic            rdy,
  output logic [CNTW-1:0] cnt,
  output logic            done,
  output logic            zero
);

  state_t          state, state_nxt;
  logic [N-1:0]    pend;
  logic [N-1:0]    rem;
  logic [N-1:0]    enc_in;
  logic [CW-1:0]   enc_idx;
  logic            enc_any;
  logic            load;
  logic            accept;

  // The single encoder sees the incoming vector while idle and the
  // post-accept remainder while emitting, so the next y is ready at the edge.
  prio_enc8_3 u_prio (
    .d   (enc_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Remainder after the current code is consumed, and the encoder input mux.
  always_comb begin
    rem      = pend;
    rem[y]   = 1'b0;
    enc_in   = (state == IDLE) ? a : rem;
    load     = (state == IDLE) && en && enc_any;
    accept   = (state == EMIT) && vld && rdy;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = EMIT;
      EMIT: if (accept && (rem == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load handshake is decoded directly from state.
  always_comb begin
    ld_rdy = (state == IDLE);
  end

  // Pending vector, code, count and status pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      y    <= '0;
      vld  <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
      zero <= 1'b0;
    end else begin
      done <= 1'b0;
      zero <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            pend <= a;
            y    <= enc_idx;
            vld  <= 1'b1;
            cnt  <= popcount(a);
          end else if (en) begin
            zero <= 1'b1;
          end
        end
        EMIT: begin
          if (accept) begin
            if (rem != '0) begin
              pend <= rem;
              y    <= enc_idx;
              cnt  <= (cnt != '0) ? cnt - CNTW'(1) : '0;
            end else begin
              pend <= '0;
              y    <= '0;
              vld  <= 1'b0;
              cnt  <= '0;
              done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enc8_3_seq.sv
// Self-checking bench for enc8_3_seq against a queue-based reference model.
module tb_enc8_3_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] a;
  logic       ld_rdy;
  logic [2:0] y;
  logic       vld;
  logic       rdy;
  logic [3:0] cnt;
  logic       done;
  logic       zero;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  enc8_3_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .a      (a),
    .ld_rdy (ld_rdy),
    .y      (y),
    .vld    (vld),
    .rdy    (rdy),
    .cnt    (cnt),
    .done   (done),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; a = '0; rdy = 1'b0;
    repeat (3) tick;
    total_cnt++; if (y !== 3'd0) $display("FAIL reset_y got=%0d exp=0", y); else pass_cnt++;
    total_cnt++; if (vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", vld); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd0) $display("FAIL reset_cnt got=%0d exp=0", cnt); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++; if (zero !== 1'b0) $display("FAIL reset_zero got=%b exp=0", zero); else pass_cnt++;
    total_cnt++; if (ld_rdy !== 1'b1) $display("FAIL reset_ld_rdy got=%b exp=1", ld_rdy); else pass_cnt++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_bit;
    rdy = 1'b1; en = 1'b1; a = 8'b0001_0000;
    tick;
    en = 1'b0;
    total_cnt++; if (y !== 3'd4) $display("FAIL single_y got=%0d exp=4", y); else pass_cnt++;
    total_cnt++; if (vld !== 1'b1) $display("FAIL single_vld got=%b exp=1", vld); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd1) $display("FAIL single_cnt got=%0d exp=1", cnt); else pass_cnt++;
    tick;
    total_cnt++; if (vld !== 1'b0) $display("FAIL single_end_vld got=%b exp=0", vld); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL single_done got=%b exp=1", done); else pass_cnt++;
    tick;
    total_cnt++; if (done !== 1'b0) $display("FAIL single_done_pulse got=%b exp=0", done); else pass_cnt++;
  endtask

  task automatic test_all_ones;
    rdy = 1'b1; en = 1'b1; a = 8'hFF;
    tick;
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (y !== 3'(7 - i)) $display("FAIL ones_y[%0d] got=%0d exp=%0d", i, y, 7 - i); else pass_cnt++;
      total_cnt++; if (cnt !== 4'(8 - i)) $display("FAIL ones_cnt[%0d] got=%0d exp=%0d", i, cnt, 8 - i); else pass_cnt++;
      total_cnt++; if (vld !== 1'b1) $display("FAIL ones_vld[%0d] got=%b exp=1", i, vld); else pass_cnt++;
      tick;
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL ones_done got=%b exp=1", done); else pass_cnt++;
    total_cnt++; if (ld_rdy !== 1'b1) $display("FAIL ones_ld_rdy got=%b exp=1", ld_rdy); else pass_cnt++;
    total_cnt++; if (vld !== 1'b0) $display("FAIL ones_end_vld got=%b exp=0", vld); else pass_cnt++;
    tick;
  endtask

  task automatic test_backpressure;
    rdy = 1'b0; en = 1'b1; a = 8'b1000_0101;
    tick;
    en = 1'b0;
    repeat (4) begin
      total_cnt++; if (y !== 3'd7) $display("FAIL bp_hold_y got=%0d exp=7", y); else pass_cnt++;
      total_cnt++; if (cnt !== 4'd3) $display("FAIL bp_hold_cnt got=%0d exp=3", cnt); else pass_cnt++;
      total_cnt++; if (vld !== 1'b1) $display("FAIL bp_hold_vld got=%b exp=1", vld); else pass_cnt++;
      tick;
    end
    rdy = 1'b1;
    tick;
    total_cnt++; if (y !== 3'd2) $display("FAIL bp_y2 got=%0d exp=2", y); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd2) $display("FAIL bp_cnt2 got=%0d exp=2", cnt); else pass_cnt++;
    tick;
    total_cnt++; if (y !== 3'd0) $display("FAIL bp_y0 got=%0d exp=0", y); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd1) $display("FAIL bp_cnt1 got=%0d exp=1", cnt); else pass_cnt++;
    tick;
    total_cnt++; if (done !== 1'b1) $display("FAIL bp_done got=%b exp=1", done); else pass_cnt++;
    tick;
  endtask

  task automatic test_zero_and_ignored;
    rdy = 1'b1; en = 1'b1; a = 8'h00;
    tick;
    en = 1'b0;
    total_cnt++; if (zero !== 1'b1) $display("FAIL zero_pulse got=%b exp=1", zero); else pass_cnt++;
    total_cnt++; if (vld !== 1'b0) $display("FAIL zero_vld got=%b exp=0", vld); else pass_cnt++;
    total_cnt++; if (ld_rdy !== 1'b1) $display("FAIL zero_ld_rdy got=%b exp=1", ld_rdy); else pass_cnt++;
    tick;
    total_cnt++; if (zero !== 1'b0) $display("FAIL zero_one_cycle got=%b exp=0", zero); else pass_cnt++;
    // Load bits 5 and 2, then try to overwrite with 8'hFF mid-emission.
    rdy = 1'b0; en = 1'b1; a = 8'b0010_0100;
    tick;
    a = 8'hFF;
    total_cnt++; if (ld_rdy !== 1'b0) $display("FAIL ign_ld_rdy got=%b exp=0", ld_rdy); else pass_cnt++;
    tick;
    en = 1'b0;
    total_cnt++; if (y !== 3'd5) $display("FAIL ign_y5 got=%0d exp=5", y); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd2) $display("FAIL ign_cnt2 got=%0d exp=2", cnt); else pass_cnt++;
    rdy = 1'b1;
    tick;
    total_cnt++; if (y !== 3'd2) $display("FAIL ign_y2 got=%0d exp=2", y); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd1) $display("FAIL ign_cnt1 got=%0d exp=1", cnt); else pass_cnt++;
    tick;
    total_cnt++; if (done !== 1'b1) $display("FAIL ign_done got=%b exp=1", done); else pass_cnt++;
    tick;
  endtask

  task automatic test_reset_mid;
    rdy = 1'b1; en = 1'b1; a = 8'hF0;
    tick;
    en = 1'b0;
    total_cnt++; if (y !== 3'd7) $display("FAIL rmid_y7 got=%0d exp=7", y); else pass_cnt++;
    tick;
    rdy = 1'b0;
    total_cnt++; if (y !== 3'd6) $display("FAIL rmid_y6 got=%0d exp=6", y); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (vld !== 1'b0) $display("FAIL rmid_vld got=%b exp=0", vld); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd0) $display("FAIL rmid_cnt got=%0d exp=0", cnt); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rmid_done got=%b exp=0", done); else pass_cnt++;
    tick;
    rst_n = 1'b1;
    total_cnt++; if (done !== 1'b0) $display("FAIL rmid_no_done got=%b exp=0", done); else pass_cnt++;
    en = 1'b1; a = 8'h01;
    tick;
    en = 1'b0;
    total_cnt++; if (y !== 3'd0) $display("FAIL rmid_reload_y got=%0d exp=0", y); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd1) $display("FAIL rmid_reload_cnt got=%0d exp=1", cnt); else pass_cnt++;
    total_cnt++; if (vld !== 1'b1) $display("FAIL rmid_reload_vld got=%b exp=1", vld); else pass_cnt++;
    rdy = 1'b1;
    tick;
    total_cnt++; if (done !== 1'b1) $display("FAIL rmid_reload_done got=%b exp=1", done); else pass_cnt++;
    tick;
  endtask

  // Random vectors with random backpressure; expected codes come from a queue
  // built by scanning the vector from bit 7 down.
  task automatic test_random;
    logic [7:0] v;
    logic       r;
    int         q[$];
    int         guard;
    for (int n = 0; n < 25; n++) begin
      v = 8'($urandom);
      if (n % 8 == 3) v = 8'h00;
      q.delete();
      for (int b = 7; b >= 0; b--) if (v[b]) q.push_back(b);
      en = 1'b1; a = v; rdy = 1'b0;
      tick;
      en = 1'b0;
      if (q.size() == 0) begin
        total_cnt++; if (zero !== 1'b1 || vld !== 1'b0) $display("FAIL rnd_zero got=%b/%b exp=1/0", zero, vld); else pass_cnt++;
        tick;
        continue;
      end
      guard = 0;
      while (q.size() > 0 && guard < 200) begin
        total_cnt++;
        if (vld !== 1'b1 || y !== 3'(q[0]) || cnt !== 4'(q.size()) || ld_rdy !== 1'b0)
          $display("FAIL rnd_emit v=%h got y=%0d cnt=%0d vld=%b exp y=%0d cnt=%0d vld=1", v, y, cnt, vld, q[0], q.size());
        else pass_cnt++;
        r = ($urandom_range(0, 3) != 0);
        rdy = r;
        tick;
        if (r) void'(q.pop_front());
        guard++;
      end
      total_cnt++;
      if (guard >= 200) $display("FAIL rnd_timeout v=%h got=%0d exp=<200", v, guard);
      else if (done !== 1'b1 || vld !== 1'b0 || ld_rdy !== 1'b1)
        $display("FAIL rnd_done v=%h got done=%b vld=%b exp done=1 vld=0", v, done, vld);
      else pass_cnt++;
      rdy = 1'b0;
      if ($urandom_range(0, 1) != 0) tick;
    end
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; en = 1'b0; a = '0; rdy = 1'b0;
    test_reset;
    test_single_bit;
    test_all_ones;
    test_backpressure;
    test_zero_and_ignored;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/enc8_3_seq.md
# enc8_3_seq

Sequential 8-to-3 encoder, the reverse direction of the team's 3-to-8 decoder. It accepts an 8-bit request vector, latches it, and emits the 3-bit index of every set bit, one code per handshake, highest index first. Downstream uses a valid/ready handshake. It sits between request-generating logic and any consumer of binary indices, for example a decoder-driven select bank.

## Interface
- N, 8, request vector width; fixed at 8 in this revision.
- CW, 3, code width; equals clog2(N).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  load strobe; sampled only while ld_rdy=1.
- a  input  8  request vector; a[7] has the highest priority.
- ld_rdy  output  1  block is idle and a load is accepted this cycle.
- y  output  3  registered code of the current highest pending bit.
- vld  output  1  y is valid.
- rdy  input  1  consumer accepts y when vld=1 and rdy=1.
- cnt  output  4  number of pending bits, including the one on y (0..8).
- done  output  1  one-cycle pulse after the final code is accepted.
- zero  output  1  one-cycle pulse when a load is attempted with a=0.

## Operation
- States: IDLE and EMIT.
- Reset values (asynchronous, rst_n=0):
  - state=IDLE, pend=0, y=0, vld=0, cnt=0, done=0, zero=0.
  - ld_rdy=1 once in IDLE; ld_rdy is decoded from state.
- IDLE, en=1, a≠0:
  - pend←a, y←highest set index of a, vld←1, cnt←popcount(a).
  - Go to EMIT.
- IDLE, en=1, a=0:
  - No load; stay in IDLE.
  - zero=1 for the next cycle.
- IDLE, en=0: hold all state. done and zero return to 0.
- EMIT:
  - ld_rdy=0; en and a are ignored.
  - On vld&&rdy, clear bit y of pend and decrement cnt.
  - If the remaining pend≠0: y←highest set index of the remaining pend; vld stays 1.
  - If the remaining pend=0: vld←0, y←0, cnt←0, done←1; go to IDLE.
- EMIT with rdy=0: y, vld, cnt and pend hold unchanged (backpressure). y never changes while vld=1 and rdy=0.
- Codes are strictly descending within one vector. Each set bit is emitted exactly once.
- cnt arithmetic: 4-bit and never wraps. The load value is 1..8; the decrement stops at 0.

## Timing
- Load latency: en sampled high at edge k gives vld=1 and a valid y from edge k on (visible in cycle k+1).
- Throughput: one code per cycle while rdy is held high. A vector with m set bits empties in m accepting cycles.
- done: asserted in the cycle after the final accept, together with vld=0 and ld_rdy=1. A new load is accepted in that same cycle, so back-to-back vectors have a one-cycle gap with vld=0.
- zero: asserted in the cycle after the rejected load; lasts one cycle.
- All outputs are registered except ld_rdy, which is decoded from state.
- Reset mid-operation:
  - Pending codes are discarded with no done pulse.
  - Outputs reach their reset values asynchronously.
  - The first load is accepted at the first rising edge after rst_n deasserts.

## Structure
- Shared package enc_pkg holds:
  - constants N=8 and CW=3;
  - the state enum {IDLE, EMIT};
  - the popcount function used for cnt.
- Sub-module prio_enc8_3:
  - purely combinational; input d[7:0], outputs idx[2:0] and any;
  - idx is the highest set bit, and idx=0 when d=0;
  - instanced once, fed by pend (and by a for the initial load).
- Top level holds the FSM, the pend register, cnt and the output registers.

## Test plan
- Reset: hold rst_n=0 for 3 cycles. Required: y=0, vld=0, cnt=0, done=0, zero=0, ld_rdy=1. Then release rst_n.
- Single bit: load a=8'b0001_0000 with rdy=1. Required: next cycle y=4, vld=1, cnt=1; following cycle vld=0, done=1.
- All ones, rdy held at 1: load a=8'hFF. Required: y=7,6,…,0 on 8 consecutive cycles; cnt goes 8→1; then done=1 and ld_rdy=1.
- Backpressure:
  - Load a=8'b1000_0101.
  - Hold rdy=0 for 4 cycles, then raise rdy=1.
  - Required: y=7 and cnt=3 stable while rdy=0; then y=2, y=0, then done.
- Zero and ignored load:
  - Load with a=0. Required: zero=1 for one cycle and no vld.
  - Pulse en with a=8'hFF during an EMIT. Required: it is ignored and codes follow the original vector.
- Reset mid-operation:
  - Load 8'hF0 and accept one code (y=7).
  - Assert rst_n=0 asynchronously. Required: immediately vld=0, cnt=0, and no done.
  - After release, load 8'h01. Required: y=0, cnt=1.
